dec_trigger_csr: RTL

Architectural trigger CSR bank in the TLU. It holds `tselect`, plus `tdata1` (mcontrol) and `tdata2` for four triggers. It services CSR reads and writes from the decode/TLU CSR path, enforces debug-mode locking, and records trigger hits. It drives the registered `trigger_pkt_any[3:0]` packet consumed by the decode PC-match logic and the LSU address/data match logic.

---
 rtl/veer_types.sv | 65 ++++++
 rtl/dec_trigger_csr_entry.sv | 72 +++++++
 rtl/dec_trigger_csr.sv | 96 +++++++++
 3 files changed

// File: rtl/veer_types.sv
// Shared VeeR types: trigger packet, tdata1 field positions, trigger CSR addresses.
package veer_types;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } trigger_pkt_t;

  // Writable/stored portion of one mcontrol (tdata1) entry
  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } tdata1_t;

  localparam logic [11:0] TSELECT = 12'h7A0;
  localparam logic [11:0] TDATA1  = 12'h7A1;
  localparam logic [11:0] TDATA2  = 12'h7A2;

  localparam int T1_DMODE   = 27;
  localparam int T1_HIT     = 20;
  localparam int T1_SELECT  = 19;
  localparam int T1_ACTION  = 12;
  localparam int T1_CHAIN   = 11;
  localparam int T1_MATCH   = 7;
  localparam int T1_M       = 6;
  localparam int T1_EXECUTE = 2;
  localparam int T1_STORE   = 1;
  localparam int T1_LOAD    = 0;

  localparam logic [3:0] T1_TYPE    = 4'd2;
  localparam logic [5:0] T1_MASKMAX = 6'd31;

  // Architectural read image of an mcontrol entry; timing and match[3:1] read 0
  function automatic logic [31:0] tdata1_pack(input tdata1_t t);
    logic [31:0] r;
    r = '0;
    r[31:28]    = T1_TYPE;
    r[T1_DMODE] = t.dmode;
    r[26:21]    = T1_MASKMAX;
    r[T1_HIT]     = t.hit;
    r[T1_SELECT]  = t.select;
    r[T1_ACTION]  = t.action;
    r[T1_CHAIN]   = t.chain;
    r[T1_MATCH]   = t.match;
    r[T1_M]       = t.m;
    r[T1_EXECUTE] = t.execute;
    r[T1_STORE]   = t.store;
    r[T1_LOAD]    = t.load;
    return r;
  endfunction

endpackage

// File: rtl/dec_trigger_csr_entry.sv
// One trigger: stored tdata1 bits, tdata2, debug-mode lock and hit capture.
module dec_trigger_csr_entry
  import veer_types::*;
#(
  parameter logic CHAIN_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         t1_wen,
  input  logic         t2_wen,
  input  logic [31:0]  wdata,
  input  logic         dbg_mode,
  input  logic         hit_set,
  output logic         locked,
  output logic [31:0]  tdata1_rd,
  output trigger_pkt_t pkt,
  output logic         chain
);

  tdata1_t     t1_q, t1_d;
  logic [31:0] t2_q, t2_d;
  logic        dmode_new;

  // A debug-owned trigger cannot be touched from machine mode
  assign locked = t1_q.dmode & ~dbg_mode;

  // Next state: CSR write wins over a hit in the same cycle
  always_comb begin
    t1_d      = t1_q;
    t2_d      = t2_q;
    dmode_new = wdata[T1_DMODE] & dbg_mode;
    if (t1_wen && !locked) begin
      t1_d.dmode   = dmode_new;
      t1_d.hit     = wdata[T1_HIT];
      t1_d.select  = wdata[T1_SELECT];
      t1_d.action  = wdata[T1_ACTION] & dmode_new;
      t1_d.chain   = CHAIN_EN & wdata[T1_CHAIN];
      t1_d.match   = wdata[T1_MATCH];
      t1_d.m       = wdata[T1_M];
      t1_d.execute = wdata[T1_EXECUTE];
      t1_d.store   = wdata[T1_STORE];
      t1_d.load    = wdata[T1_LOAD];
    end else if (hit_set) begin
      t1_d.hit = 1'b1;
    end
    if (t2_wen && !locked) begin
      t2_d = wdata;
    end
  end

  // State flops, cleared asynchronously
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      t1_q <= '0;
      t2_q <= '0;
    end else begin
      t1_q <= t1_d;
      t2_q <= t2_d;
    end
  end

  assign tdata1_rd   = tdata1_pack(t1_q);
  assign chain       = t1_q.chain;
  assign pkt.select  = t1_q.select;
  assign pkt.match   = t1_q.match;
  assign pkt.store   = t1_q.store;
  assign pkt.load    = t1_q.load;
  assign pkt.execute = t1_q.execute;
  assign pkt.m       = t1_q.m;
  assign pkt.tdata2  = t2_q;

endmodule

// File: rtl/dec_trigger_csr.sv
// Trigger CSR bank: tselect, address decode, chain cross-check, read mux, packets.
module dec_trigger_csr
  import veer_types::*;
#(
  parameter int NUM_TRIG = 4
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         dec_csr_wen,
  input  logic [11:0]                  dec_csr_waddr,
  input  logic [31:0]                  dec_csr_wdata,
  input  logic [11:0]                  dec_csr_raddr,
  input  logic                         dbg_mode,
  input  logic [3:0]                   update_hit_bit,
  output logic [31:0]                  csr_rdata,
  output logic                         csr_rhit,
  output trigger_pkt_t [NUM_TRIG-1:0]  trigger_pkt_any,
  output logic [1:0]                   trigger_chain
);

  logic [1:0]          tselect_q, tselect_d;
  logic                we_tsel, we_t1, we_t2;
  logic [NUM_TRIG-1:0] t1_wen, t2_wen, locked, chain, chain_blk;
  logic [31:0]         tdata1_rd [NUM_TRIG];
  logic                unused_chain;

  assign we_tsel = dec_csr_wen & (dec_csr_waddr == TSELECT);
  assign we_t1   = dec_csr_wen & (dec_csr_waddr == TDATA1);
  assign we_t2   = dec_csr_wen & (dec_csr_waddr == TDATA2);

  // tselect update
  always_comb begin
    tselect_d = tselect_q;
    if (we_tsel) tselect_d = dec_csr_wdata[1:0];
  end

  // tselect register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) tselect_q <= '0;
    else        tselect_q <= tselect_d;
  end

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    // Chaining an even trigger onto a debug-owned odd partner is refused
    if (g % 2 == 0) begin : g_even
      assign chain_blk[g] = dec_csr_wdata[T1_CHAIN] & locked[g+1];
    end else begin : g_odd
      assign chain_blk[g] = 1'b0;
    end

    assign t1_wen[g] = we_t1 & (tselect_q == g[1:0]) & ~chain_blk[g];
    assign t2_wen[g] = we_t2 & (tselect_q == g[1:0]);

    dec_trigger_csr_entry #(
      .CHAIN_EN ((g % 2) == 0)
    ) u_entry (
      .clk       (clk),
      .rst_l     (rst_l),
      .t1_wen    (t1_wen[g]),
      .t2_wen    (t2_wen[g]),
      .wdata     (dec_csr_wdata),
      .dbg_mode  (dbg_mode),
      .hit_set   (update_hit_bit[g]),
      .locked    (locked[g]),
      .tdata1_rd (tdata1_rd[g]),
      .pkt       (trigger_pkt_any[g]),
      .chain     (chain[g])
    );
  end

  // Odd triggers always hold chain=0
  assign unused_chain  = chain[1] ^ chain[3];
  assign trigger_chain = {chain[2], chain[0]};

  // Combinational read of stored state
  always_comb begin
    csr_rdata = '0;
    csr_rhit  = 1'b0;
    case (dec_csr_raddr)
      TSELECT: begin
        csr_rdata = {30'd0, tselect_q};
        csr_rhit  = 1'b1;
      end
      TDATA1: begin
        csr_rdata = tdata1_rd[tselect_q];
        csr_rhit  = 1'b1;
      end
      TDATA2: begin
        csr_rdata = trigger_pkt_any[tselect_q].tdata2;
        csr_rhit  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
